axis_i2c_slave: RTL and testbench
=================================

// Module: axis_i2c_slave
// PURPOSE
//  I2C target (responder) answering the I2C master at a single 7-bit address. Bytes written by
//  the master leave on an AXI-Stream master port; bytes read by the master are taken from an
//  AXI-Stream slave port. Oversampled design: SCL/SDA are synchronised into clk_i. No clock
//  stretching. Used as bus-functional partner and FPGA-side target for the I2C master.
// PARAMETERS
//  SLAVE_ADDR  7'h50  7-bit device address matched after START
//  SYNC_STAGES 2      synchroniser depth on SCL and SDA (>=2)
// PORTS
//  clk_i          in   1  system clock; must be >= 20x SCL frequency
//  rst_i          in   1  synchronous reset, active-high
//  i2c_scl_i      in   1  SCL from pad (input only, never driven)
//  i2c_sda_i      in   1  SDA from pad
//  i2c_sda_oe_o   out  1  1 = pull SDA low (open drain), 0 = release
//  m_axis_tdata   out  8  byte written by master
//  m_axis_tvalid  out  1  byte valid
//  m_axis_tready  in   1  sink ready
//  s_axis_tdata   in   8  byte to return on master read
//  s_axis_tvalid  in   1  read byte available
//  s_axis_tready  out  1  one-cycle pulse when the read byte is consumed
//  busy_o         out  1  1 from address match until STOP / non-matching START
//  overrun_o      out  1  sticky: write byte dropped (cleared by rst_i only)
//  underrun_o     out  1  sticky: read with no s_axis data, 0xFF sent
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, shift reg 0, sync flops 1 (bus idle high).
//  Sampling: SYNC_STAGES flops + 1 edge-detect flop; SCL rise/fall and START/STOP are single-cycle
//   strobes. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//  START/STOP win over any state: START (incl. repeated) -> ADDR, bit cnt 0, sda_oe 0;
//   STOP -> IDLE, sda_oe 0, busy 0. Data bits are sampled on SCL rise; sda_oe changes only on SCL fall.
//  States:
//   IDLE     : wait START.
//   ADDR     : shift 8 bits MSB first on SCL rise. At bit 8: addr==SLAVE_ADDR -> ACK_ADDR,
//              busy=1, latch R/W; else -> IDLE (ignore until next START).
//   ACK_ADDR : on SCL fall after bit 8 drive sda_oe=1; on next SCL fall release.
//              W -> WRITE. R -> load read byte (below) -> READ.
//   WRITE    : shift 8 bits. At bit 8: if output reg empty -> load m_axis_tdata, tvalid=1,
//              go ACK_WR with ACK; else drop byte, overrun_o=1, go ACK_WR with NACK.
//   ACK_WR   : ACK -> sda_oe=1 for the 9th clock; NACK -> sda_oe stays 0. Then WRITE.
//   READ     : on each SCL fall drive sda_oe = ~bit (MSB first); after 8th bit's SCL fall
//              release SDA -> RD_ACK.
//   RD_ACK   : sample SDA on 9th SCL rise. 0 (ACK) -> load next byte, READ. 1 (NACK) -> IDLE
//              (stays busy-less until next START; no SDA drive).
//  Read byte load: if s_axis_tvalid -> take s_axis_tdata, s_axis_tready pulses 1 cycle;
//   else byte=8'hFF, underrun_o=1, no tready pulse.
//  m_axis: tvalid held with stable tdata until tready; tvalid&tready clears it next cycle.
//   Byte is presented within 1 cycle of the 8th SCL rise strobe; ready may arrive any time.
//  Simultaneous: STOP/START in same cycle as SCL edge strobe -> START/STOP handled, edge ignored.
//   Byte completion and tready in same cycle -> handshake of old byte counts, new byte accepted.
//  rst_i mid-transfer: SDA released immediately, pending m_axis byte discarded, FSM IDLE.
// TESTING
//  1. Write 0xA0 (addr 0x50,W), 0x12, 0x34, STOP, tready=1 -> ACK on all 3 bytes; m_axis 0x12 then 0x34; busy 0 after STOP.
//  2. Addr 0x51 W, 0x55 -> no ACK (SDA high on 9th clk), no m_axis traffic, busy stays 0.
//  3. Read 0xA1, s_axis holds 0xC3,0x5A; master ACKs then NACKs -> SDA bits 0xC3,0x5A; two tready pulses; IDLE.
//  4. Read 0xA1 with s_axis_tvalid=0 -> 0xFF returned, underrun_o=1, no tready pulse.
//  5. Write 3 bytes with tready=0 -> byte1 ACKed & held, bytes 2,3 NACKed, overrun_o=1, m_axis_tdata stays byte1.
//  6. Write 0xA0,0x00, repeated START, 0xA1, read 1 byte; plus rst_i mid-byte -> sda_oe 0 next cycle, IDLE.

Source files
------------

// File: rtl/axis_i2c_slave.sv
// I2C target at a single 7-bit address. Bytes the master writes leave on m_axis.
// Bytes the master reads are taken from s_axis. SCL and SDA are oversampled into clk_i.
module axis_i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_oe_o,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy_o,
  output logic       overrun_o,
  output logic       underrun_o
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_ADDR, ST_WRITE, ST_ACK_WR, ST_READ, ST_RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise_c, scl_fall_c, start_c, stop_c;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [7:0]         sr, sr_nxt;
  logic               rw, rw_nxt;
  logic               ack, ack_nxt;
  logic               sda_oe_nxt, busy_nxt, overrun_nxt, underrun_nxt;
  logic [7:0]         m_tdata_nxt;
  logic               m_tvalid_nxt, s_tready_nxt;
  logic [7:0]         rd_byte_c;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise_c = scl_s & ~scl_d;
  assign scl_fall_c = ~scl_s & scl_d;
  assign start_c    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c     = scl_s & scl_d & ~sda_d & sda_s;
  assign rd_byte_c  = s_axis_tvalid ? s_axis_tdata : 8'hFF;

  // Pad synchronisers plus one edge-detect stage; idle bus reads high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      sr            <= '0;
      rw            <= 1'b0;
      ack           <= 1'b0;
      i2c_sda_oe_o  <= 1'b0;
      busy_o        <= 1'b0;
      overrun_o     <= 1'b0;
      underrun_o    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      sr            <= sr_nxt;
      rw            <= rw_nxt;
      ack           <= ack_nxt;
      i2c_sda_oe_o  <= sda_oe_nxt;
      busy_o        <= busy_nxt;
      overrun_o     <= overrun_nxt;
      underrun_o    <= underrun_nxt;
      m_axis_tdata  <= m_tdata_nxt;
      m_axis_tvalid <= m_tvalid_nxt;
      s_axis_tready <= s_tready_nxt;
    end
  end

  // Next-state and output decode; bus conditions take priority over SCL edges
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    sr_nxt       = sr;
    rw_nxt       = rw;
    ack_nxt      = ack;
    sda_oe_nxt   = i2c_sda_oe_o;
    busy_nxt     = busy_o;
    overrun_nxt  = overrun_o;
    underrun_nxt = underrun_o;
    m_tdata_nxt  = m_axis_tdata;
    m_tvalid_nxt = m_axis_tvalid & ~m_axis_tready;
    s_tready_nxt = 1'b0;

    if (start_c) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_c) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise_c) begin
          sr_nxt      = {sr[6:0], sda_s};
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(7)) begin
            bit_cnt_nxt = '0;
            if (sr[6:0] == SLAVE_ADDR) begin
              state_nxt = ST_ACK_ADDR;
              busy_nxt  = 1'b1;
              rw_nxt    = sda_s;
            end else begin
              state_nxt = ST_IDLE;
              busy_nxt  = 1'b0;
            end
          end
        end
        // Bit count 0/1 marks the first and second SCL fall of the ACK slot
        ST_ACK_ADDR: if (scl_fall_c) begin
          if (bit_cnt == '0) begin
            sda_oe_nxt  = 1'b1;
            bit_cnt_nxt = CNT_W'(1);
          end else if (!rw) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = ST_WRITE;
          end else begin
            // This fall also opens the first read bit, so drive its MSB now
            sr_nxt       = {rd_byte_c[6:0], 1'b0};
            sda_oe_nxt   = ~rd_byte_c[7];
            bit_cnt_nxt  = CNT_W'(1);
            s_tready_nxt = s_axis_tvalid;
            underrun_nxt = underrun_o | ~s_axis_tvalid;
            state_nxt    = ST_READ;
          end
        end
        ST_WRITE: if (scl_rise_c) begin
          sr_nxt      = {sr[6:0], sda_s};
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(7)) begin
            bit_cnt_nxt = '0;
            state_nxt   = ST_ACK_WR;
            if (!m_axis_tvalid || m_axis_tready) begin
              m_tdata_nxt  = {sr[6:0], sda_s};
              m_tvalid_nxt = 1'b1;
              ack_nxt      = 1'b1;
            end else begin
              overrun_nxt = 1'b1;
              ack_nxt     = 1'b0;
            end
          end
        end
        ST_ACK_WR: if (scl_fall_c) begin
          if (bit_cnt == '0) begin
            sda_oe_nxt  = ack;
            bit_cnt_nxt = CNT_W'(1);
          end else begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = ST_WRITE;
          end
        end
        ST_READ: if (scl_fall_c) begin
          if (bit_cnt == CNT_W'(8)) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = ST_RD_ACK;
          end else begin
            sda_oe_nxt  = ~sr[7];
            sr_nxt      = {sr[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
        ST_RD_ACK: if (scl_rise_c) begin
          if (!sda_s) begin
            sr_nxt       = rd_byte_c;
            bit_cnt_nxt  = '0;
            s_tready_nxt = s_axis_tvalid;
            underrun_nxt = underrun_o | ~s_axis_tvalid;
            state_nxt    = ST_READ;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_i2c_slave.sv
// Directed I2C transactions with random payloads against a transaction-level model.
module tb_axis_i2c_slave;

  localparam int unsigned HALF = 10;

  logic       clk;
  logic       rst_i;
  logic       scl;
  logic       m_sda;
  logic       sda_oe;
  logic       sda_bus;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       busy, overrun, underrun;

  assign sda_bus = m_sda & ~sda_oe;

  axis_i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i2c_scl_i(scl), .i2c_sda_i(sda_bus), .i2c_sda_oe_o(sda_oe),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .busy_o(busy), .overrun_o(overrun), .underrun_o(underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Observed traffic
  logic [7:0] got_q[$];
  int         rd_pulses = 0;

  always @(negedge clk) begin
    if (!rst_i && m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    if (s_axis_tready) rd_pulses++;
  end

  // Transaction-level model: one-byte holding slot, sticky flags, expected stream
  logic [7:0] exp_q[$];
  logic       mdl_full = 1'b0;
  logic [7:0] mdl_byte = 8'h00;
  logic       mdl_ovr = 1'b0;
  logic       mdl_und = 1'b0;
  int         exp_pulses = 0;

  function automatic logic addr_hit(input logic [7:0] a);
    return a[7:1] == 7'h50;
  endfunction

  task automatic model_wr(input logic [7:0] b, output logic exp_ack);
    if (!mdl_full) begin
      mdl_full = 1'b1;
      mdl_byte = b;
      exp_ack  = 1'b1;
    end else begin
      mdl_ovr = 1'b1;
      exp_ack = 1'b0;
    end
  endtask

  task automatic model_drain(input logic sink_ready);
    if (mdl_full && sink_ready) begin
      exp_q.push_back(mdl_byte);
      mdl_full = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_rd(input logic valid, input logic [7:0] data);
    if (valid) begin
      exp_pulses++;
      return data;
    end
    mdl_und = 1'b1;
    return 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'h100, 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // I2C master bus-functional tasks; SCL is low between bits
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    cyc(4); m_sda = b; cyc(6);
    scl = 1'b1; cyc(HALF);
    scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    cyc(4); m_sda = 1'b1; cyc(6);
    scl = 1'b1; cyc(HALF / 2);
    b = sda_bus; cyc(HALF / 2);
    scl = 1'b0;
  endtask

  task automatic i2c_start;
    cyc(4); m_sda = 1'b1; cyc(6);
    scl = 1'b1; cyc(HALF);
    m_sda = 1'b0; cyc(HALF);
    scl = 1'b0;
  endtask

  task automatic i2c_stop;
    cyc(4); m_sda = 1'b0; cyc(6);
    scl = 1'b1; cyc(HALF);
    m_sda = 1'b1; cyc(HALF);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(s);
    acked = ~s;
  endtask

  task automatic read_bits(output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_in(s);
      b[i] = s;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, eack, s;
    logic [7:0] d[3];
    logic [7:0] r1, r2, rb, eb;

    rst_i = 1'b1; scl = 1'b1; m_sda = 1'b1;
    m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00;
    cyc(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    rst_i = 1'b0;
    cyc(5);

    // Addressed write of two random bytes, sink always ready
    m_axis_tready = 1'b1;
    d[0] = 8'($urandom); d[1] = 8'($urandom);
    i2c_start;
    write_byte(8'hA0, ack);
    chk("t1_addr_ack", ack, addr_hit(8'hA0));
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 2; i++) begin
      write_byte(d[i], ack);
      model_wr(d[i], eack);
      model_drain(m_axis_tready);
      chk("t1_data_ack", ack, eack);
    end
    i2c_stop; cyc(5);
    chk("t1_busy_after_stop", busy, 0);
    chk_stream("t1_stream");

    // Foreign address: no ACK anywhere, no traffic
    i2c_start;
    write_byte(8'hA2, ack);
    chk("t2_addr_ack", ack, addr_hit(8'hA2));
    chk("t2_busy", busy, 0);
    write_byte(8'($urandom), ack);
    chk("t2_data_ack", ack, 0);
    i2c_stop; cyc(5);
    chk_stream("t2_stream");

    // Read of two bytes, master ACKs then NACKs
    r1 = 8'($urandom); r2 = 8'($urandom);
    s_axis_tvalid = 1'b1; s_axis_tdata = r1;
    rd_pulses = 0; exp_pulses = 0;
    i2c_start;
    write_byte(8'hA1, ack);
    chk("t3_addr_ack", ack, addr_hit(8'hA1));
    eb = model_rd(s_axis_tvalid, s_axis_tdata);
    read_bits(rb);
    s_axis_tdata = r2;
    bit_out(1'b0);
    chk("t3_byte0", rb, eb);
    eb = model_rd(s_axis_tvalid, s_axis_tdata);
    read_bits(rb);
    bit_out(1'b1);
    chk("t3_byte1", rb, eb);
    cyc(4);
    chk("t3_busy_after_nack", busy, 0);
    i2c_stop; cyc(5);
    chk("t3_tready_pulses", rd_pulses, exp_pulses);
    chk("t3_underrun", underrun, mdl_und);

    // Read with empty source: 0xFF and underrun
    s_axis_tvalid = 1'b0;
    rd_pulses = 0; exp_pulses = 0;
    i2c_start;
    write_byte(8'hA1, ack);
    chk("t4_addr_ack", ack, 1);
    eb = model_rd(s_axis_tvalid, s_axis_tdata);
    read_bits(rb);
    bit_out(1'b1);
    i2c_stop; cyc(5);
    chk("t4_byte", rb, eb);
    chk("t4_underrun", underrun, mdl_und);
    chk("t4_tready_pulses", rd_pulses, exp_pulses);

    // Sink stalled: first byte held, later bytes dropped
    m_axis_tready = 1'b0;
    d[0] = 8'($urandom); d[1] = 8'($urandom); d[2] = 8'($urandom);
    i2c_start;
    write_byte(8'hA0, ack);
    chk("t5_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) begin
      write_byte(d[i], ack);
      model_wr(d[i], eack);
      chk("t5_data_ack", ack, eack);
    end
    i2c_stop; cyc(5);
    chk("t5_overrun", overrun, mdl_ovr);
    chk("t5_tvalid", m_axis_tvalid, mdl_full);
    chk("t5_tdata", m_axis_tdata, mdl_byte);
    m_axis_tready = 1'b1;
    model_drain(m_axis_tready);
    cyc(3);
    chk("t5_tvalid_drained", m_axis_tvalid, 0);
    chk_stream("t5_stream");

    // Write, repeated START, read one byte
    d[0] = 8'($urandom); r1 = 8'($urandom);
    rd_pulses = 0; exp_pulses = 0;
    i2c_start;
    write_byte(8'hA0, ack);
    chk("t6_addr_w_ack", ack, 1);
    write_byte(d[0], ack);
    model_wr(d[0], eack);
    model_drain(m_axis_tready);
    chk("t6_data_ack", ack, eack);
    i2c_start;
    write_byte(8'hA1, ack);
    chk("t6_addr_r_ack", ack, 1);
    s_axis_tvalid = 1'b1; s_axis_tdata = r1;
    eb = model_rd(s_axis_tvalid, s_axis_tdata);
    read_bits(rb);
    bit_out(1'b1);
    i2c_stop; cyc(5);
    chk("t6_read", rb, eb);
    chk("t6_tready_pulses", rd_pulses, exp_pulses);
    chk_stream("t6_stream");

    // Reset in the middle of a read byte while a write byte is pending
    m_axis_tready = 1'b0;
    i2c_start;
    write_byte(8'hA0, ack);
    write_byte(8'($urandom), ack);
    chk("t7_pending_ack", ack, 1);
    i2c_start;
    write_byte(8'hA1, ack);
    s_axis_tdata = 8'h00;
    for (int i = 0; i < 3; i++) bit_in(s);
    cyc(4);
    chk("t7_sda_driven", sda_oe, 1);
    chk("t7_tvalid_pending", m_axis_tvalid, 1);
    rst_i = 1'b1;
    cyc(1);
    chk("t7_sda_released", sda_oe, 0);
    chk("t7_tvalid_cleared", m_axis_tvalid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_overrun_cleared", overrun, 0);
    chk("t7_underrun_cleared", underrun, 0);
    rst_i = 1'b0;
    mdl_full = 1'b0; mdl_ovr = 1'b0; mdl_und = 1'b0;
    s_axis_tvalid = 1'b0;
    m_sda = 1'b1; cyc(4);
    scl = 1'b1; cyc(20);
    got_q.delete();

    // Target responds normally after the reset
    m_axis_tready = 1'b1;
    d[0] = 8'($urandom);
    i2c_start;
    write_byte(8'hA0, ack);
    chk("t8_addr_ack", ack, 1);
    write_byte(d[0], ack);
    model_wr(d[0], eack);
    model_drain(m_axis_tready);
    chk("t8_data_ack", ack, eack);
    i2c_stop; cyc(5);
    chk_stream("t8_stream");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
